// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. It drives every datapath enable and
// mux select and the 3-bit ALUOp class from the state and the opcode captured in DECODE.
module multicycle_control #(
    localparam int unsigned OP_W    = 6,
    localparam int unsigned ALUOP_W = 3,
    localparam int unsigned SEL_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    Opcode,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [SEL_W-1:0]   PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               InstrDone,
    output logic               IllegalOp
);

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'b101;
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b111;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_SEXT = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_ZEXT = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU  = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_JUMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_JUMP      = 4'd10
    } state_e;

    state_e             state_q, state_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic [SEL_W-1:0]   imm_srcb_c;
    logic [ALUOP_W-1:0] imm_aluop_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Immediate-type operand select and ALU class, shared by I_EXEC and I_WB.
    always_comb begin
        imm_srcb_c  = SRCB_SEXT;
        imm_aluop_c = ALUOP_ADD;
        case (opcode_q)
            OP_ORI: begin
                imm_srcb_c  = SRCB_ZEXT;
                imm_aluop_c = ALUOP_ORI;
            end
            OP_LUI: begin
                imm_srcb_c  = SRCB_ZEXT;
                imm_aluop_c = ALUOP_LUI;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = S_FETCH;
        opcode_d  = opcode_q;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        PCSource  = PCSRC_ALU;
        ALUOp     = ALUOP_ADD;
        InstrDone = 1'b0;
        IllegalOp = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // Reset gates the loads so MemReady cannot leak through while held in reset.
                PCWrite = MemReady & reset;
                IRWrite = MemReady & reset;
                state_d = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                opcode_d = Opcode;
                case (Opcode)
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_RTYPE:                 state_d = S_R_EXEC;
                    OP_ADDI, OP_ORI, OP_LUI:  state_d = S_I_EXEC;
                    OP_J:                     state_d = S_JUMP;
                    default: begin
                        IllegalOp = 1'b1;
                        InstrDone = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SEXT;
                state_d = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MemReady ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
                state_d   = MemReady ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RTYPE;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = imm_srcb_c;
                ALUOp   = imm_aluop_c;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite  = 1'b1;
                ALUSrcB   = imm_srcb_c;
                ALUOp     = imm_aluop_c;
                InstrDone = 1'b1;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = PCSRC_JUMP;
                InstrDone = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction streams with memory stalls, summarised
// per instruction and compared against a latency/activity model of the control rules.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk, reset, MemReady;
    logic [5:0] Opcode;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       InstrDone, IllegalOp;

    int n_cmp = 0;
    int n_err = 0;

    // Per-instruction activity summary; 8'hff marks "never happened".
    typedef struct packed {
        logic [7:0] cycles;
        logic [7:0] mem_read;
        logic [7:0] mem_write;
        logic [7:0] iord;
        logic [7:0] pc_write;
        logic [7:0] ir_write;
        logic [7:0] reg_write;
        logic [7:0] rw_cycle;
        logic [7:0] wb_regdst;
        logic [7:0] wb_memtoreg;
        logic [7:0] illegal;
        logic [7:0] illegal_cycle;
        logic [7:0] srca;
        logic [7:0] exec_aluop;
        logic [7:0] exec_srcb;
        logic [7:0] last_pcsrc;
        logic [7:0] last_aluop;
        logic [7:0] last_srcb;
        logic [7:0] fetch_srcb;
        logic [7:0] fetch_aluop;
        logic [7:0] overlap;
    } summ_t;

    multicycle_control dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .PCSource  (PCSource),
        .ALUOp     (ALUOp),
        .InstrDone (InstrDone),
        .IllegalOp (IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] outs();
        return {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, ALUOp, InstrDone, IllegalOp};
    endfunction

    function automatic logic [17:0] mk(input logic pcw, input logic iord, input logic mr,
                                       input logic mw, input logic irw, input logic rd,
                                       input logic m2r, input logic rw, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ps,
                                       input logic [2:0] aop, input logic done,
                                       input logic ill);
        return {pcw, iord, mr, mw, irw, rd, m2r, rw, sa, sb, ps, aop, done, ill};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_J};
    endfunction

    // Reference: what a whole instruction should look like given fetch and memory stalls.
    function automatic summ_t model(input logic [5:0] op, input int sf, input int sm);
        summ_t e;
        bit is_lw  = (op == OP_LW);
        bit is_sw  = (op == OP_SW);
        bit is_r   = (op == OP_R);
        bit is_j   = (op == OP_J);
        bit is_i   = (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LUI);
        bit ill    = !is_legal(op);
        bit wb     = is_lw || is_r || is_i;
        int lat    = is_lw ? 5 : (is_sw || is_r || is_i) ? 4 : is_j ? 3 : 2;
        int stall  = (is_lw || is_sw) ? sm : 0;
        e = '0;
        e.cycles        = 8'(lat + sf + stall);
        e.mem_read      = 8'(sf + 1 + (is_lw ? sm + 1 : 0));
        e.mem_write     = 8'(is_sw ? sm + 1 : 0);
        e.iord          = 8'((is_lw || is_sw) ? sm + 1 : 0);
        e.pc_write      = 8'(is_j ? 2 : 1);
        e.ir_write      = 8'd1;
        e.reg_write     = 8'(wb);
        e.rw_cycle      = wb ? 8'(lat + sf + stall - 1) : 8'hff;
        e.wb_regdst     = 8'(is_r);
        e.wb_memtoreg   = 8'(is_lw);
        e.illegal       = 8'(ill);
        e.illegal_cycle = ill ? 8'(sf + 1) : 8'hff;
        e.srca          = 8'(!is_j && !ill);
        if (is_r)                   begin e.exec_aluop = 8'd7; e.exec_srcb = 8'd0; end
        else if (op == OP_ORI)      begin e.exec_aluop = 8'd5; e.exec_srcb = 8'd3; end
        else if (op == OP_LUI)      begin e.exec_aluop = 8'd3; e.exec_srcb = 8'd3; end
        else if (is_i || is_lw || is_sw) begin e.exec_aluop = 8'd4; e.exec_srcb = 8'd2; end
        e.last_pcsrc    = is_j ? 8'd2 : 8'd0;
        e.last_aluop    = is_i ? e.exec_aluop : 8'd4;
        e.last_srcb     = is_i ? e.exec_srcb : 8'd0;
        e.fetch_srcb    = 8'd1;
        e.fetch_aluop   = 8'd4;
        e.overlap       = 8'd0;
        return e;
    endfunction

    // Runs one instruction from the start of a FETCH cycle and summarises what the DUT did.
    task automatic run_instr(input logic [5:0] op, input int sf, input int sm, output summ_t s);
        bit is_mem;
        bit done;
        int k;
        is_mem = (op == OP_LW) || (op == OP_SW);
        done   = 1'b0;
        k      = 0;
        s = '0;
        s.rw_cycle      = 8'hff;
        s.illegal_cycle = 8'hff;
        while (!done && k < 40) begin
            if (k < sf)                     MemReady = 1'b0;
            else if (k == sf)               MemReady = 1'b1;
            else if (is_mem && k >= sf + 3) MemReady = (k >= sf + 3 + sm);
            else                            MemReady = 1'($urandom);
            Opcode = (k == sf + 1) ? op : 6'($urandom);
            @(negedge clk);
            if (k == 0) begin
                s.fetch_srcb  = 8'(ALUSrcB);
                s.fetch_aluop = 8'(ALUOp);
            end
            if (MemRead)             s.mem_read  = s.mem_read + 8'd1;
            if (MemWrite)            s.mem_write = s.mem_write + 8'd1;
            if (IorD)                s.iord      = s.iord + 8'd1;
            if (PCWrite)             s.pc_write  = s.pc_write + 8'd1;
            if (IRWrite)             s.ir_write  = s.ir_write + 8'd1;
            if (MemRead && MemWrite) s.overlap   = s.overlap + 8'd1;
            if (RegWrite) begin
                s.reg_write   = s.reg_write + 8'd1;
                s.rw_cycle    = 8'(k);
                s.wb_regdst   = 8'(RegDst);
                s.wb_memtoreg = 8'(MemtoReg);
            end
            if (ALUSrcA) begin
                s.srca       = s.srca + 8'd1;
                s.exec_aluop = 8'(ALUOp);
                s.exec_srcb  = 8'(ALUSrcB);
            end
            if (IllegalOp) begin
                s.illegal       = s.illegal + 8'd1;
                s.illegal_cycle = 8'(k);
            end
            if (InstrDone) begin
                done         = 1'b1;
                s.cycles     = 8'(k + 1);
                s.last_pcsrc = 8'(PCSource);
                s.last_aluop = 8'(ALUOp);
                s.last_srcb  = 8'(ALUSrcB);
            end
            @(posedge clk);
            #1;
            k++;
        end
        if (!done) s.cycles = 8'hee;
    endtask

    task automatic do_reset();
        MemReady = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] exp_rst;
        exp_rst = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b100, 0, 0);
        reset = 1'b0; MemReady = 1'b1; Opcode = OP_R;
        #3;
        n_cmp++;
        if (outs() !== exp_rst) begin
            n_err++; $display("FAIL reset_initial: got %b want %b", outs(), exp_rst);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (outs() !== exp_rst) begin
            n_err++; $display("FAIL reset_held: got %b want %b", outs(), exp_rst);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b100, 0, 0)) begin
            n_err++; $display("FAIL reset_release_fetch: got %b", outs());
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (outs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b100, 0, 0)) begin
            n_err++; $display("FAIL reset_then_decode: got %b", outs());
        end
        do_reset();
    endtask

    task automatic test_rtype();
        summ_t got, exp;
        run_instr(OP_R, 0, 0, got);
        exp = model(OP_R, 0, 0);
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL rtype: got %h want %h", got, exp); end
    endtask

    task automatic test_itype();
        summ_t got, exp;
        int sf;
        sf = $urandom_range(0, 2);
        run_instr(OP_ORI, sf, 0, got);
        exp = model(OP_ORI, sf, 0);
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL ori: got %h want %h", got, exp); end
        sf = $urandom_range(0, 2);
        run_instr(OP_LUI, sf, 0, got);
        exp = model(OP_LUI, sf, 0);
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL lui: got %h want %h", got, exp); end
        run_instr(OP_ADDI, 0, 0, got);
        exp = model(OP_ADDI, 0, 0);
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL addi: got %h want %h", got, exp); end
    endtask

    task automatic test_lw_stall();
        summ_t got, exp;
        run_instr(OP_LW, 0, 2, got);
        exp = model(OP_LW, 0, 2);
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL lw_stall: got %h want %h", got, exp); end
        n_cmp++;
        if (got.cycles !== 8'd7) begin
            n_err++; $display("FAIL lw_stall_cycles: got %0d want 7", got.cycles);
        end
    endtask

    task automatic test_sw();
        summ_t got, exp;
        run_instr(OP_SW, 0, 0, got);
        exp = model(OP_SW, 0, 0);
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL sw: got %h want %h", got, exp); end
    endtask

    task automatic test_illegal();
        summ_t got, exp;
        run_instr(6'b111111, 0, 0, got);
        exp = model(6'b111111, 0, 0);
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL illegal: got %h want %h", got, exp); end
    endtask

    task automatic test_jump();
        summ_t got, exp;
        run_instr(OP_J, 1, 0, got);
        exp = model(OP_J, 1, 0);
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL jump: got %h want %h", got, exp); end
    endtask

    task automatic test_reset_mid();
        MemReady = 1'b1; Opcode = OP_R;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++;
        if (outs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b111, 0, 0)) begin
            n_err++; $display("FAIL mid_rexec: got %b", outs());
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b100, 0, 0)) begin
            n_err++; $display("FAIL mid_async_reset: got %b", outs());
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b100, 0, 0)) begin
            n_err++; $display("FAIL mid_restart_decode: got %b", outs());
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (outs() !== mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b100, 1, 0)) begin
            n_err++; $display("FAIL mid_restart_rwb: got %b", outs());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        summ_t got, exp;
        logic [5:0] op;
        int sf, sm;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: op = OP_R;
                1: op = OP_ADDI;
                2: op = OP_ORI;
                3: op = OP_LUI;
                4: op = OP_LW;
                5: op = OP_SW;
                6: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            sf = $urandom_range(0, 2);
            sm = $urandom_range(0, 3);
            run_instr(op, sf, sm, got);
            exp = model(op, sf, sm);
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random[%0d] op=%b sf=%0d sm=%0d: got %h want %h",
                         i, op, sf, sm, got, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b0; MemReady = 1'b0; Opcode = '0;
        test_reset();
        test_rtype();
        test_itype();
        test_lw_stall();
        test_sw();
        test_illegal();
        test_jump();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
